// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one single-ported, variable-latency memory between
// instruction fetch and data accesses. Data has priority; a starvation counter forces fetches.
module mem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_ack_o,

    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ack_o,

    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,

    output logic              stall_o
);

    localparam int unsigned CntW = $clog2(STARVE_MAX + 1);
    localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_MAX);

    typedef enum logic [1:0] {StIdle, StBusyI, StBusyD, StDone} state_e;

    state_e              state_q, state_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                if_ack_q, if_ack_d;
    logic                dm_ack_q, dm_ack_d;
    logic [DATA_W-1:0]   if_data_q, if_data_d;
    logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
    logic [CntW-1:0]     starve_q, starve_d;
    logic                force_fetch;

    assign force_fetch = (starve_q == StarveMax);

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;
        if_data_d   = if_data_q;
        dm_rdata_d  = dm_rdata_q;
        starve_d    = starve_q;

        case (state_q)
            StIdle: begin
                if (dm_req_i && !(if_req_i && force_fetch)) begin
                    state_d     = StBusyD;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we_i;
                    mem_addr_d  = dm_addr_i;
                    mem_wdata_d = dm_wdata_i;
                    // Only reached with if_req_i set when below the limit, so no overflow.
                    if (if_req_i && !force_fetch) begin
                        starve_d = starve_q + CntW'(1);
                    end
                end else if (if_req_i) begin
                    state_d     = StBusyI;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr_i;
                    mem_wdata_d = '0;
                    starve_d    = '0;
                end
            end
            StBusyI: begin
                if (mem_ack_i) begin
                    state_d   = StDone;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if_ack_d  = 1'b1;
                    if_data_d = mem_rdata_i;
                end
            end
            StBusyD: begin
                if (mem_ack_i) begin
                    state_d   = StDone;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    dm_ack_d  = 1'b1;
                    if (!mem_we_q) begin
                        dm_rdata_d = mem_rdata_i;
                    end
                end
            end
            StDone: begin
                // One cycle so the acked requester can drop req before it is resampled.
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            if_data_q   <= '0;
            dm_rdata_q  <= '0;
            starve_q    <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ack_q    <= if_ack_d;
            dm_ack_q    <= dm_ack_d;
            if_data_q   <= if_data_d;
            dm_rdata_q  <= dm_rdata_d;
            starve_q    <= starve_d;
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign if_ack_o    = if_ack_q;
    assign dm_ack_o    = dm_ack_q;
    assign if_data_o   = if_data_q;
    assign dm_rdata_o  = dm_rdata_q;

    // Low in the ack cycle so the pipeline advances exactly on the ack edge.
    assign stall_o = (if_req_i & ~if_ack_q) | (dm_req_i & ~dm_ack_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, waited write, contention, starvation, reset abort,
// spurious memory acks.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_data;
    logic        if_ack;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall;

    int n_vec;
    int n_err;

    mem_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .STARVE_MAX (4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_data_o   (if_data),
        .if_ack_o    (if_ack),
        .dm_req_i    (dm_req),
        .dm_we_i     (dm_we),
        .dm_addr_i   (dm_addr),
        .dm_wdata_i  (dm_wdata),
        .dm_rdata_o  (dm_rdata),
        .dm_ack_o    (dm_ack),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .mem_ack_i   (mem_ack),
        .stall_o     (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    initial begin
        logic        exp_f;
        logic [31:0] exp_addr;
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        mem_rdata = '0;
        mem_ack   = 1'b0;

        // Reset state
        cyc();
        cyc();
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_acks", {30'b0, if_ack, dm_ack}, 32'd0);
        chk("rst_if_data", if_data, 32'd0);
        chk("rst_dm_rdata", dm_rdata, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        rst = 1'b0;

        // Single fetch, zero wait states
        cyc();
        if_req  = 1'b1;
        if_addr = 32'h0000_0010;
        #1 chk("f1_stall_c0", {31'b0, stall}, 32'd1);
        cyc();
        chk("f1_mem_req", {31'b0, mem_req}, 32'd1);
        chk("f1_mem_addr", mem_addr, 32'h10);
        chk("f1_mem_we", {31'b0, mem_we}, 32'd0);
        chk("f1_mem_wdata", mem_wdata, 32'd0);
        chk("f1_if_ack_c1", {31'b0, if_ack}, 32'd0);
        chk("f1_stall_c1", {31'b0, stall}, 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h2002_0005;
        cyc();
        mem_ack = 1'b0;
        chk("f1_if_ack_c2", {31'b0, if_ack}, 32'd1);
        chk("f1_if_data", if_data, 32'h2002_0005);
        chk("f1_mem_req_c2", {31'b0, mem_req}, 32'd0);
        chk("f1_stall_c2", {31'b0, stall}, 32'd0);
        if_req = 1'b0;
        cyc();
        chk("f1_if_ack_c3", {31'b0, if_ack}, 32'd0);
        chk("f1_if_data_hold", if_data, 32'h2002_0005);

        // Data write with 3 wait states; requester inputs change mid-access
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 32'h20;
        dm_wdata = 32'hDEAD_BEEF;
        cyc();
        for (int i = 0; i < 4; i++) begin
            chk("w_mem_req", {31'b0, mem_req}, 32'd1);
            chk("w_mem_we", {31'b0, mem_we}, 32'd1);
            chk("w_mem_addr", mem_addr, 32'h20);
            chk("w_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
            chk("w_dm_ack_wait", {31'b0, dm_ack}, 32'd0);
            if (i == 1) begin
                dm_wdata = 32'h0;
                dm_addr  = 32'h99;
            end
            if (i == 3) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'h1234_5678;
            end
            cyc();
        end
        mem_ack = 1'b0;
        chk("w_dm_ack", {31'b0, dm_ack}, 32'd1);
        chk("w_if_ack", {31'b0, if_ack}, 32'd0);
        chk("w_dm_rdata_unch", dm_rdata, 32'd0);
        chk("w_mem_req_clr", {31'b0, mem_req}, 32'd0);
        chk("w_mem_we_clr", {31'b0, mem_we}, 32'd0);
        dm_req = 1'b0;
        dm_we  = 1'b0;
        cyc();
        chk("w_dm_ack_once", {31'b0, dm_ack}, 32'd0);

        // Simultaneous fetch and data read: data first
        if_req  = 1'b1;
        if_addr = 32'h40;
        dm_req  = 1'b1;
        dm_addr = 32'h80;
        cyc();
        chk("s_mem_addr_d", mem_addr, 32'h80);
        chk("s_mem_we_d", {31'b0, mem_we}, 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFE_0001;
        cyc();
        mem_ack = 1'b0;
        chk("s_dm_ack", {31'b0, dm_ack}, 32'd1);
        chk("s_if_ack_n", {31'b0, if_ack}, 32'd0);
        chk("s_dm_rdata", dm_rdata, 32'hCAFE_0001);
        chk("s_stall_fetch_pend", {31'b0, stall}, 32'd1);
        dm_req = 1'b0;
        cyc();
        chk("s_dm_ack_once", {31'b0, dm_ack}, 32'd0);
        chk("s_idle_no_req", {31'b0, mem_req}, 32'd0);
        cyc();
        chk("s_mem_req_f", {31'b0, mem_req}, 32'd1);
        chk("s_mem_addr_f", mem_addr, 32'h40);
        mem_ack   = 1'b1;
        mem_rdata = 32'h0BAD_F00D;
        cyc();
        mem_ack = 1'b0;
        chk("s_if_ack", {31'b0, if_ack}, 32'd1);
        chk("s_dm_ack_n", {31'b0, dm_ack}, 32'd0);
        chk("s_if_data", if_data, 32'h0BAD_F00D);
        chk("s_dm_rdata_hold", dm_rdata, 32'hCAFE_0001);
        if_req = 1'b0;
        cyc();
        chk("s_if_ack_once", {31'b0, if_ack}, 32'd0);

        // Starvation: expected grants D D D D F D F (round 5 shows the counter cleared)
        for (int g = 0; g < 7; g++) begin
            exp_f    = (g == 4 || g == 6);
            if_req   = 1'b1;
            if_addr  = 32'h200 + g;
            dm_req   = (g < 6);
            dm_we    = 1'b0;
            dm_addr  = 32'h100 + g;
            exp_addr = exp_f ? 32'h200 + g : 32'h100 + g;
            cyc();
            chk("st_mem_req", {31'b0, mem_req}, 32'd1);
            chk("st_grant_addr", mem_addr, exp_addr);
            mem_ack   = 1'b1;
            mem_rdata = 32'hA000_0000 + g;
            cyc();
            mem_ack = 1'b0;
            chk("st_if_ack", {31'b0, if_ack}, {31'b0, exp_f});
            chk("st_dm_ack", {31'b0, dm_ack}, {31'b0, ~exp_f});
            if (exp_f) begin
                chk("st_if_data", if_data, 32'hA000_0000 + g);
            end else begin
                chk("st_dm_rdata", dm_rdata, 32'hA000_0000 + g);
            end
            if (exp_f) if_req = 1'b0;
            else       dm_req = 1'b0;
            cyc();
        end
        if_req = 1'b0;
        dm_req = 1'b0;

        // Reset asserted in BUSY_D
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h300;
        cyc();
        chk("r_busy_req", {31'b0, mem_req}, 32'd1);
        #2 rst = 1'b1;
        #1 chk("r_async_drop", {31'b0, mem_req}, 32'd0);
        dm_req = 1'b0;
        cyc();
        rst     = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 32'h5555_AAAA;
        cyc();
        mem_ack = 1'b0;
        chk("r_late_ack_acks", {30'b0, if_ack, dm_ack}, 32'd0);
        chk("r_late_ack_req", {31'b0, mem_req}, 32'd0);
        chk("r_dm_rdata_clr", dm_rdata, 32'd0);

        // Fetch after reset completes with minimum latency
        if_req  = 1'b1;
        if_addr = 32'h400;
        cyc();
        chk("r_f_mem_req", {31'b0, mem_req}, 32'd1);
        chk("r_f_mem_addr", mem_addr, 32'h400);
        mem_ack   = 1'b1;
        mem_rdata = 32'h7777_0001;
        cyc();
        mem_ack = 1'b0;
        chk("r_f_if_ack", {31'b0, if_ack}, 32'd1);
        chk("r_f_if_data", if_data, 32'h7777_0001);
        if_req = 1'b0;
        cyc();

        // Spurious mem_ack in IDLE, then a normal data read still starts on time
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_0000;
        cyc();
        mem_ack = 1'b0;
        chk("sp_acks", {30'b0, if_ack, dm_ack}, 32'd0);
        chk("sp_mem_req", {31'b0, mem_req}, 32'd0);
        chk("sp_data_hold", if_data, 32'h7777_0001);
        dm_req  = 1'b1;
        dm_addr = 32'h500;
        cyc();
        chk("sp_d_mem_req", {31'b0, mem_req}, 32'd1);
        chk("sp_d_mem_addr", mem_addr, 32'h500);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1357_2468;
        cyc();
        mem_ack = 1'b0;
        chk("sp_d_dm_ack", {31'b0, dm_ack}, 32'd1);
        chk("sp_d_dm_rdata", dm_rdata, 32'h1357_2468);
        dm_req = 1'b0;
        // Spurious ack in DONE is ignored too
        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
        chk("sp_done_acks", {30'b0, if_ack, dm_ack}, 32'd0);
        chk("sp_done_req", {31'b0, mem_req}, 32'd0);
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that lets the pipeline's instruction-fetch (IF) port and data-memory (MEM-stage) port share one single-ported, variable-latency memory. It sequences one access at a time with a req/ack handshake and grants each request exactly once. It produces a pipeline stall while any request is outstanding, to be OR-ed into the PC/IFID write enables. Data accesses have priority, and a starvation counter guarantees fetch progress.

## Interface
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- STARVE_MAX, 4, consecutive data grants made while a fetch is pending before one fetch is forced (≥1)
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- if_req_i  in  1  fetch request, level; held until if_ack_o
- if_addr_i  in  ADDR_W  fetch address
- if_data_o  out  DATA_W  fetched instruction, valid while if_ack_o
- if_ack_o  out  1  one-cycle completion pulse for fetch
- dm_req_i  in  1  data request, level; held until dm_ack_o
- dm_we_i  in  1  1 = write, 0 = read
- dm_addr_i  in  ADDR_W  data address
- dm_wdata_i  in  DATA_W  write data
- dm_rdata_o  out  DATA_W  read data, valid while dm_ack_o after a read
- dm_ack_o  out  1  one-cycle completion pulse for data
- mem_req_o  out  1  memory request, held until mem_ack_i
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_rdata_i  in  DATA_W  memory read data, valid with mem_ack_i
- mem_ack_i  in  1  memory completion, one cycle
- stall_o  out  1  combinational: (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o)

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D, DONE.
- IDLE: requests are sampled only in this state.
  - If only one requester is active, grant it.
  - If both are active, grant data, unless starve_cnt == STARVE_MAX, in which case grant fetch.
  - On a grant, register the address, we and wdata into the mem_* outputs, set mem_req_o = 1, and go to BUSY_D or BUSY_I.
  - For a fetch grant, mem_we_o = 0 and mem_wdata_o = 0.
- BUSY_x: hold mem_* outputs stable.
  - On mem_ack_i: clear mem_req_o and mem_we_o, and pulse the corresponding ack next cycle. Go to DONE.
  - On a data read completion, register mem_rdata_i into dm_rdata_o; on a fetch completion, register it into if_data_o.
  - Writes leave dm_rdata_o unchanged.
- DONE: exactly one cycle, with the granted ack high. Then go to IDLE unconditionally. This guarantees the requester has dropped or changed req before it is resampled.
- starve_cnt is a saturating counter, width clog2(STARVE_MAX+1).
  - Increments on each data grant made while if_req_i = 1.
  - Clears on any fetch grant.
  - Holds otherwise.
- mem_ack_i in IDLE or DONE is ignored and causes no state change.
- Requester inputs changing during BUSY have no effect, because the outputs are latched at grant.
- if_data_o and dm_rdata_o hold their last values between accesses.

## Timing
- Reset values (async, immediate): state IDLE, all mem_* outputs 0, if_ack_o and dm_ack_o 0, if_data_o and dm_rdata_o 0, starve_cnt 0.
- Reset asserted mid-access: the access is abandoned and mem_req_o drops immediately. A mem_ack_i arriving after reset is ignored.
- Minimum access latency:
  - Request seen in IDLE at cycle 0.
  - mem_req_o high in cycle 1.
  - mem_ack_i in cycle 1.
  - Ack out in cycle 2.
  - IDLE in cycle 3, so the next grant is at the edge ending cycle 3.
- Throughput is at most one access per 3 cycles.
- Memory wait states: each cycle without mem_ack_i adds exactly one cycle of latency.
- stall_o is combinational from inputs and registered acks. It is low in the ack cycle, so the pipeline advances exactly on the ack edge.

## Test plan
- Single fetch, addr 0x0000_0010, mem_ack_i one cycle after mem_req_o, rdata 0x2002_0005:
  - mem_addr_o = 0x10 and mem_we_o = 0.
  - if_ack_o pulses for 1 cycle, 2 cycles after the request, with if_data_o = 0x2002_0005.
  - stall_o is high for 2 cycles.
- Data write, addr 0x20, wdata 0xDEAD_BEEF, memory with 3 wait states:
  - mem_we_o = 1 and mem_wdata_o = 0xDEAD_BEEF, held stable for 4 cycles.
  - dm_ack_o pulses once, and dm_rdata_o is unchanged.
- Simultaneous fetch and data read:
  - Data is granted first.
  - After dm_ack_o and DONE, the fetch is granted in the next IDLE.
  - Each ack pulses exactly once.
- Starvation: hold if_req_i high and re-raise dm_req_i immediately after each ack, with STARVE_MAX = 4:
  - Exactly 4 data grants, then a fetch grant, then starve_cnt = 0.
- Reset asserted in BUSY_D:
  - mem_req_o drops asynchronously and no ack is produced.
  - A late mem_ack_i is ignored.
  - After reset release, a new fetch completes normally.
- Spurious mem_ack_i in IDLE: no state change and no ack output.
